rf_param: RTL and testbench
===========================

Name: rf_param

Overview:
- Parametrised successor to the single-write, two-read MIPS register file.
- Configurable width, depth and read-port count; the number of read ports is set by a parameter.
- Adds a synchronous self-clearing sequence after reset, a per-register pending-write scoreboard for the pipelined core's hazard unit, and optional write-to-read bypass.
- Sits between decode (reads, scoreboard set) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, 5, address width, equals log2(DEPTH).
- NRD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ra  in  NRD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd  out  NRD*DATA_W  packed read data, combinational.
- rpend  out  NRD  pending flag of the register addressed by each read port.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- pset  in  1  mark a register pending (a producer was issued).
- paddr  in  ADDR_W  register to mark.
- busy  out  1  clear sequence in progress.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high; all state changes on posedge clk.
- FSM states: CLEAR and RUN.
  - rst=1 at an edge: state becomes CLEAR, index counter idx becomes 0, all scoreboard bits become 0.
  - In CLEAR, at each edge rf[idx]<=0 and idx<=idx+1. At the edge where idx==DEPTH-1, state becomes RUN. The clear takes exactly DEPTH cycles after reset deasserts.
  - rst asserted mid-CLEAR restarts at idx=0.
  - rst asserted in RUN behaves as a fresh reset.
- busy=1 in CLEAR, 0 in RUN. Reset value of busy is 1.
- While busy=1:
  - all rd outputs are 0 and all rpend outputs are 0;
  - we and pset are ignored.
- Read, RUN state, port k:
  - if ZERO_REG=1 and address==0, rd=0;
  - else if the bypass condition holds (see Optional Feature), rd=wd;
  - else rd=rf[addr].
- Write, RUN state: if we=1, and not (ZERO_REG=1 and wa==0), then rf[wa]<=wd at the edge. Data is truncated to or fits DATA_W exactly; no sign handling.
- Scoreboard, RUN state, per edge:
  - we=1 clears pend[wa];
  - pset=1 sets pend[paddr];
  - set and clear of the same address in the same cycle: set wins, because a new producer supersedes the completing one;
  - paddr==0 with ZERO_REG=1 is ignored.
- rpend[k]=pend[ra_k], combinational from the registered bit. The current-cycle we does not clear it early.
- Out-of-range addresses cannot occur because DEPTH=2^ADDR_W.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: a read port whose address equals wa, while we=1 in RUN and the address is non-zero (or ZERO_REG=0), returns wd in the same cycle. Its rpend is also forced to 0 in that cycle.
- Undefined: reads return the stored value. A same-cycle write is visible from the next cycle; rpend is the registered bit only.

Test Plan:
- Reset and clear: pulse rst for 1 cycle with DEPTH=32 -> busy=1 for exactly 32 cycles, then 0; every register reads 0; rd=0 throughout busy.
- Basic write/read: we=1, wa=5, wd=0xDEADBEEF, then ra0=5, ra1=0 -> rd0=0xDEADBEEF, rd1=0.
- Zero-register writes: we=1, wa=0, wd=0x12345678 -> port 0 reads 0 at address 0, and keeps reading 0 afterwards.
- Scoreboard:
  - pset with paddr=7, then read ra0=7 -> rpend0=1;
  - we with wa=7 -> rpend0=0 on the next cycle;
  - pset and we both on address 7 in one cycle -> rpend0 stays 1.
- Bypass, same-cycle we with wa=9, wd=0xA5A5A5A5 and ra1=9:
  - with RF_BYPASS_EN defined -> rd1=0xA5A5A5A5 in that cycle;
  - without it -> rd1 shows the old value that cycle and 0xA5A5A5A5 on the next.
- Reset mid-clear: assert rst at clear cycle 10 -> busy stays 1 for a further 32 cycles; writes attempted during busy are lost (register 3 reads 0 after clear).

Source files
------------

// File: rtl/rf_param.sv
`default_nettype none
// ============================================================================
// rf_param : parametrised register file, self-clear after reset, pending-write
//            scoreboard; optional write-to-read bypass via RF_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module rf_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [NRD-1:0]          rpend,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic                    pset,
  input  logic [ADDR_W-1:0]       paddr,
  output logic                    busy
);

  localparam bit c_zero_en = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic [DATA_W-1:0]   r_rf [DEPTH];
  logic [DEPTH-1:0]    r_pend;
  logic                w_run;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // The clear sweep shares the single write port with normal writeback.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_run       = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = wa;
    w_wr_data   = wd;
    case (r_state)
      S_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_idx;
        w_wr_data = '0;
        w_idx_nxt = r_idx + ADDR_W'(1);
        if (r_idx == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run   = 1'b1;
        w_wr_en = we && !(c_zero_en && (wa == '0));
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign busy = !w_run;

  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_rf[w_wr_addr] <= w_wr_data;
    end
  end

  // Set is applied after clear so a newly issued producer supersedes the retiring one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else if (w_run) begin
      if (we) begin
        r_pend[wa] <= 1'b0;
      end
      if (pset && !(c_zero_en && (paddr == '0))) begin
        r_pend[paddr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_pnd;
    logic              w_byp;

    assign w_addr = ra[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    assign w_byp = we && (w_addr == wa);
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
      w_data = r_rf[w_addr];
      w_pnd  = r_pend[w_addr];
      if (!w_run || (c_zero_en && (w_addr == '0))) begin
        w_data = '0;
        w_pnd  = 1'b0;
      end else if (w_byp) begin
        w_data = wd;
        w_pnd  = 1'b0;
      end
    end

    assign rd[k*DATA_W +: DATA_W] = w_data;
    assign rpend[k]               = w_pnd;
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_param.sv
`default_nettype none
// ============================================================================
// tb_rf_param : directed + random checks of rf_param against an array model.
// Revision    : 1.0
// ============================================================================
module tb_rf_param;

  localparam int DW  = 32;
  localparam int DEP = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rpend;
  logic             we;
  logic [AW-1:0]    wa;
  logic [DW-1:0]    wd;
  logic             pset;
  logic [AW-1:0]    paddr;
  logic             busy;

  rf_param #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rpend(rpend), .we(we), .wa(wa),
    .wd(wd), .pset(pset), .paddr(paddr), .busy(busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_mem  [DEP];
  bit          m_pend [DEP];
  int          m_left;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    logic [31:0]   e;
    bit            p;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_left > 0));
    for (int k = 0; k < NR; k++) begin
      a = ra[k*AW +: AW];
      if (m_left > 0 || a == 0) begin
        e = 0; p = 0;
      end else if (BYP && we && a == wa) begin
        e = wd; p = 0;
      end else begin
        e = m_mem[a]; p = m_pend[a];
      end
      chk($sformatf("rd%0d", k), rd[k*DW +: DW], e);
      chk($sformatf("rpend%0d", k), 32'(rpend[k]), 32'(p));
    end
  endtask

  task automatic edge_upd();
    @(posedge clk);
    if (rst) begin
      m_left = DEP;
      for (int i = 0; i < DEP; i++) begin
        m_pend[i] = 0;
        m_mem[i]  = 0;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (we) begin
        if (wa != 0) m_mem[wa] = wd;
        m_pend[wa] = 0;
      end
      if (pset && paddr != 0) m_pend[paddr] = 1;
    end
    #1;
  endtask

  task automatic cyc();
    check_all();
    edge_upd();
  endtask

  task automatic rnd_inputs();
    ra    = (NR*AW)'($urandom);
    we    = 1'($urandom);
    wa    = AW'($urandom);
    wd    = $urandom;
    pset  = ($urandom_range(0, 3) == 0);
    paddr = AW'($urandom);
  endtask

  // Counts busy cycles while hammering register 3 with writes and pend sets.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      ra = (NR*AW)'($urandom);
      we = 1'b1; wa = AW'(3); wd = $urandom;
      pset = 1'b1; paddr = AW'(3);
      check_all();
      if (!busy) begin
        we = 1'b0; pset = 1'b0;
        edge_upd();
        break;
      end
      cnt++;
      edge_upd();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b0; pset = 1'b0; ra = '0; wa = '0; wd = '0; paddr = '0;
    m_left = DEP;
    edge_upd();
    rst = 1'b0;

    count_busy(n);
    chk("clear_len", 32'(n), 32'd32);

    we = 1'b0; pset = 1'b0;
    for (int i = 0; i < DEP / 2; i++) begin
      ra = {AW'(2 * i + 1), AW'(2 * i)};
      cyc();
    end

    we = 1'b1; wa = AW'(5); wd = 32'hDEADBEEF; ra = '0;
    cyc();
    we = 1'b0; ra = {AW'(0), AW'(5)};
    check_all();
    chk("wr5_rd0", rd[31:0], 32'hDEADBEEF);
    chk("wr5_rd1", rd[63:32], 32'h0);
    edge_upd();

    we = 1'b1; wa = AW'(0); wd = 32'h12345678; ra = '0;
    check_all();
    chk("zero_same", rd[31:0], 32'h0);
    edge_upd();
    we = 1'b0;
    check_all();
    chk("zero_after", rd[31:0], 32'h0);
    edge_upd();

    pset = 1'b1; paddr = AW'(7);
    cyc();
    pset = 1'b0; ra = {AW'(0), AW'(7)};
    check_all();
    chk("pend_set", 32'(rpend[0]), 32'd1);
    edge_upd();
    we = 1'b1; wa = AW'(7); wd = 32'h00000077;
    check_all();
    chk("pend_same_cycle", 32'(rpend[0]), BYP ? 32'd0 : 32'd1);
    edge_upd();
    we = 1'b0;
    check_all();
    chk("pend_clr", 32'(rpend[0]), 32'd0);
    edge_upd();
    pset = 1'b1; paddr = AW'(7); we = 1'b1; wa = AW'(7); wd = 32'h00000707;
    cyc();
    pset = 1'b0; we = 1'b0;
    check_all();
    chk("pend_setwins", 32'(rpend[0]), 32'd1);
    edge_upd();

    we = 1'b1; wa = AW'(9); wd = 32'h11111111;
    cyc();
    wd = 32'hA5A5A5A5; ra = {AW'(9), AW'(0)};
    check_all();
    chk("byp_same", rd[63:32], BYP ? 32'hA5A5A5A5 : 32'h11111111);
    edge_upd();
    we = 1'b0;
    check_all();
    chk("byp_next", rd[63:32], 32'hA5A5A5A5);
    edge_upd();

    for (int i = 0; i < 400; i++) begin
      rnd_inputs();
      cyc();
    end

    rst = 1'b1; we = 1'b0; pset = 1'b0;
    edge_upd();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rnd_inputs();
      cyc();
    end
    rst = 1'b1;
    check_all();
    edge_upd();
    rst = 1'b0;
    count_busy(n);
    chk("reclear_len", 32'(n), 32'd32);
    we = 1'b0; pset = 1'b0; ra = {AW'(0), AW'(3)};
    check_all();
    chk("reg3_lost", rd[31:0], 32'h0);
    chk("reg3_pend", 32'(rpend[0]), 32'd0);
    edge_upd();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
